atr_parser: RTL
===============

ATR_PARSER -- requirements
Module: atr_parser

Interface
REQ-001 Parameter MAX_ATR_BYTES, default 33, maximum ATR length in bytes including TS.
REQ-002 Parameter MAX_GROUPS, default 8, maximum interface-byte groups (TA..TD index i).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse; aborts any parse and arms for a new ATR.
REQ-006 rxData  in  8  byte from the ISO7816-3 master, already convention-corrected.
REQ-007 rxValid  in  1  one-cycle strobe, rxData valid.
REQ-008 busy  out  1  parse in progress.
REQ-009 atrDone  out  1  ATR complete and consistent; held until start or reset.
REQ-010 atrError  out  1  parse failed; held until start or reset.
REQ-011 errorCode  out  2  0 none, 1 bad TS, 2 TCK mismatch, 3 length/group overflow.
REQ-012 ta1  out  8  TA1 value (Fi/Di), 0x11 if absent.
REQ-013 tc1  out  8  TC1 value (extra guard time), 0x00 if absent.
REQ-014 firstProtocol  out  4  T from TD1 low nibble, 0 if TD1 absent.
REQ-015 histLen  out  4  K from T0 low nibble.
REQ-016 histData  out  8  current historical byte.
REQ-017 histValid  out  1  one-cycle strobe per historical byte.

Function
REQ-018 States: IDLE, TS, T0, IFACE, HIST, TCK, DONE, ERR.
REQ-019 IDLE -> TS on start; start in any state restarts at TS, clearing all captured values and XOR accumulator.
REQ-020 TS: accept 0x3B or 0x3F -> T0; any other value -> ERR, errorCode=1.
REQ-021 T0: histLen<=low nibble, presence mask Y<=high nibble, i<=1, XOR accumulator starts at T0.
REQ-022 IFACE: consume TAi, TBi, TCi, TDi in that order, only those flagged in current Y; empty Y -> HIST immediately (no byte consumed).
REQ-023 TDi: Y<=TDi[7:4], i<=i+1; if TDi[3:0]!=0 set tckRequired.
REQ-024 i exceeding MAX_GROUPS -> ERR, errorCode=3.
REQ-025 HIST: forward each byte on histData/histValid same cycle as captured (1-cycle latency from rxValid); after K bytes -> TCK if tckRequired else DONE; K=0 skips directly.
REQ-026 TCK: XOR of all bytes T0..TCK must be 0 -> DONE, else ERR errorCode=2.
REQ-027 Byte count (TS inclusive) reaching MAX_ATR_BYTES+1 -> ERR, errorCode=3.
REQ-028 All bytes from T0 onward feed the XOR accumulator regardless of tckRequired.
REQ-029 rxValid in IDLE, DONE, ERR ignored; outputs unchanged.
REQ-030 start and rxValid in same cycle: start wins, byte discarded.
REQ-031 atrDone/atrError asserted the cycle after the final accepted byte; busy high in TS..TCK only.
REQ-032 State transitions occur only on rxValid except the zero-byte skips in REQ-022/025, which take one cycle.

Reset
REQ-033 reset: state IDLE; busy, atrDone, atrError, histValid 0; errorCode 0; ta1 0x11; tc1 0x00; firstProtocol 0; histLen 0; histData 0.
REQ-034 reset mid-parse discards partial ATR; no strobes emitted in the reset cycle.

Structure
REQ-035 Shared package holds the state encoding, errorCode constants, and TS direct/inverse constants (0x3B/0x3F), shared with the master.
REQ-036 Single flat module; no sub-module needed.

Verification
REQ-037 start; bytes 3B 00 -> atrDone=1, histLen=0, firstProtocol=0, ta1=0x11, no histValid.
REQ-038 start; 3B 12 96 14 50 -> ta1=0x96, histLen=2, two histValid strobes 0x14, 0x50, atrDone=1.
REQ-039 start; 3B 80 01 81 -> firstProtocol=1, TCK accepted, atrDone=1; same with TCK 0x80 -> atrError, errorCode=2.
REQ-040 start; TS 0x12 -> atrError, errorCode=1, later bytes ignored.
REQ-041 start; 3B 02 AA then start; 3B 00 -> no error, atrDone=1; reset asserted mid-ATR -> all outputs at reset values.
REQ-042 Chain of TD bytes 0x80 repeated beyond MAX_GROUPS -> atrError, errorCode=3.

Source files
------------

// File: rtl/atr_parser_pkg.sv
// Shared definitions for the ATR parser and the ISO7816-3 master:
// FSM state encoding, error codes and the TS convention bytes.
package atr_parser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TS    = 3'd1,
    ST_T0    = 3'd2,
    ST_IFACE = 3'd3,
    ST_HIST  = 3'd4,
    ST_TCK   = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } atr_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_TS   = 2'd1;
  localparam logic [1:0] ERR_TCK      = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  localparam logic [7:0] TS_DIRECT  = 8'h3B;
  localparam logic [7:0] TS_INVERSE = 8'h3F;

  localparam logic [7:0] TA1_DEFAULT = 8'h11;

endpackage

// File: rtl/atr_parser.sv
// ATR parser: walks an ISO7816-3 Answer-To-Reset byte stream, captures
// TA1/TC1/first protocol/K, forwards historical bytes and checks TCK.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               pulse: abort any parse and arm for a new ATR
//   rxData, rxValid     convention-corrected byte stream from the master
//   busy                parse in progress (TS..TCK)
//   atrDone, atrError   sticky completion flags, errorCode gives the cause
//   ta1, tc1            captured interface bytes of group 1 (or defaults)
//   firstProtocol       T from TD1, histLen = K from T0
//   histData, histValid historical byte stream, one strobe per byte
module atr_parser
  import atr_parser_pkg::*;
#(
  parameter int unsigned MAX_ATR_BYTES = 33,
  parameter int unsigned MAX_GROUPS    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] rxData,
  input  logic       rxValid,
  output logic       busy,
  output logic       atrDone,
  output logic       atrError,
  output logic [1:0] errorCode,
  output logic [7:0] ta1,
  output logic [7:0] tc1,
  output logic [3:0] firstProtocol,
  output logic [3:0] histLen,
  output logic [7:0] histData,
  output logic       histValid
);

  localparam int unsigned CNT_W = $clog2(MAX_ATR_BYTES + 2);
  localparam int unsigned GRP_W = $clog2(MAX_GROUPS + 2);

  atr_state_t       state;
  logic [3:0]       yMask;        // {TD, TC, TB, TA} still expected in this group
  logic [GRP_W-1:0] groupIdx;
  logic             tckRequired;
  logic [7:0]       xorAcc;
  logic [CNT_W-1:0] byteCnt;
  logic [3:0]       histCnt;
  logic             byteAtLimit;

  // The next accepted byte would be byte MAX_ATR_BYTES+1.
  assign byteAtLimit = (byteCnt == CNT_W'(MAX_ATR_BYTES));

  // Parser FSM with registered outputs. Zero-byte skips (empty Y, K done)
  // take one cycle each and do not consume rxValid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      atrDone       <= 1'b0;
      atrError      <= 1'b0;
      errorCode     <= ERR_NONE;
      ta1           <= TA1_DEFAULT;
      tc1           <= 8'h00;
      firstProtocol <= 4'h0;
      histLen       <= 4'h0;
      histData      <= 8'h00;
      histValid     <= 1'b0;
      yMask         <= 4'h0;
      groupIdx      <= '0;
      tckRequired   <= 1'b0;
      xorAcc        <= 8'h00;
      byteCnt       <= '0;
      histCnt       <= 4'h0;
    end else begin
      histValid <= 1'b0;
      if (start) begin
        // Start wins over a coincident byte and clears everything captured.
        state         <= ST_TS;
        busy          <= 1'b1;
        atrDone       <= 1'b0;
        atrError      <= 1'b0;
        errorCode     <= ERR_NONE;
        ta1           <= TA1_DEFAULT;
        tc1           <= 8'h00;
        firstProtocol <= 4'h0;
        histLen       <= 4'h0;
        histData      <= 8'h00;
        yMask         <= 4'h0;
        groupIdx      <= '0;
        tckRequired   <= 1'b0;
        xorAcc        <= 8'h00;
        byteCnt       <= '0;
        histCnt       <= 4'h0;
      end else if (rxValid && busy && byteAtLimit) begin
        state     <= ST_ERR;
        busy      <= 1'b0;
        atrError  <= 1'b1;
        errorCode <= ERR_OVERFLOW;
      end else begin
        case (state)
          ST_TS: begin
            if (rxValid) begin
              byteCnt <= byteCnt + CNT_W'(1);
              if (rxData == TS_DIRECT || rxData == TS_INVERSE) begin
                state <= ST_T0;
              end else begin
                state     <= ST_ERR;
                busy      <= 1'b0;
                atrError  <= 1'b1;
                errorCode <= ERR_BAD_TS;
              end
            end
          end
          ST_T0: begin
            if (rxValid) begin
              byteCnt  <= byteCnt + CNT_W'(1);
              histLen  <= rxData[3:0];
              yMask    <= rxData[7:4];
              groupIdx <= GRP_W'(1);
              xorAcc   <= rxData;
              state    <= ST_IFACE;
            end
          end
          ST_IFACE: begin
            if (yMask == 4'h0) begin
              state <= ST_HIST;
            end else if (rxValid) begin
              byteCnt <= byteCnt + CNT_W'(1);
              xorAcc  <= xorAcc ^ rxData;
              if (yMask[0]) begin
                if (groupIdx == GRP_W'(1)) ta1 <= rxData;
                yMask[0] <= 1'b0;
              end else if (yMask[1]) begin
                yMask[1] <= 1'b0;
              end else if (yMask[2]) begin
                if (groupIdx == GRP_W'(1)) tc1 <= rxData;
                yMask[2] <= 1'b0;
              end else begin
                if (groupIdx == GRP_W'(1)) firstProtocol <= rxData[3:0];
                if (rxData[3:0] != 4'h0) tckRequired <= 1'b1;
                if (groupIdx == GRP_W'(MAX_GROUPS)) begin
                  state     <= ST_ERR;
                  busy      <= 1'b0;
                  atrError  <= 1'b1;
                  errorCode <= ERR_OVERFLOW;
                end else begin
                  yMask    <= rxData[7:4];
                  groupIdx <= groupIdx + GRP_W'(1);
                end
              end
            end
          end
          ST_HIST: begin
            if (histCnt == histLen) begin
              // K=0: leave without consuming a byte.
              if (tckRequired) begin
                state <= ST_TCK;
              end else begin
                state   <= ST_DONE;
                busy    <= 1'b0;
                atrDone <= 1'b1;
              end
            end else if (rxValid) begin
              byteCnt   <= byteCnt + CNT_W'(1);
              xorAcc    <= xorAcc ^ rxData;
              histData  <= rxData;
              histValid <= 1'b1;
              histCnt   <= histCnt + 4'd1;
              if (histCnt + 4'd1 == histLen) begin
                if (tckRequired) begin
                  state <= ST_TCK;
                end else begin
                  state   <= ST_DONE;
                  busy    <= 1'b0;
                  atrDone <= 1'b1;
                end
              end
            end
          end
          ST_TCK: begin
            if (rxValid) begin
              byteCnt <= byteCnt + CNT_W'(1);
              xorAcc  <= xorAcc ^ rxData;
              busy    <= 1'b0;
              if ((xorAcc ^ rxData) == 8'h00) begin
                state   <= ST_DONE;
                atrDone <= 1'b1;
              end else begin
                state     <= ST_ERR;
                atrError  <= 1'b1;
                errorCode <= ERR_TCK;
              end
            end
          end
          default: ;  // IDLE, DONE, ERR hold everything and ignore bytes
        endcase
      end
    end
  end

endmodule
